// File: rtl/reorder_buffer.sv
`default_nettype none
// reorder_buffer: 3-wide circular ROB with in-order allocate/retire and out-of-order completion.
// A branch recovery squashes every entry. Way 2 is the oldest slot on every 3-wide bus.
module reorder_buffer #(
  parameter int ROB  = 5,
  parameter int PR   = 6,
  parameter int XLEN = 32,
  localparam int ROBW = 2**ROB,
  localparam int PKT  = 1 + 2*PR + 5 + 2 + XLEN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3*PKT-1:0]    rob_in,
  input  logic [2:0]          complete_valid,
  input  logic [3*ROB-1:0]    complete_entry,
  input  logic [2:0]          precise_state_valid,
  input  logic [3*XLEN-1:0]   target_pc,
  input  logic                BPRecoverEN,
  output logic [3*ROB-1:0]    dispatch_index,
  output logic [3*PKT-1:0]    retire_entry,
  output logic [2:0]          struct_stall,
  output logic [ROBW*PKT-1:0] rob_entries_display,
  output logic [ROB-1:0]      head_display,
  output logic [ROB-1:0]      tail_display
);

  localparam int VALID_BIT = PKT - 1;
  localparam int COMP_BIT  = XLEN + 1;
  localparam int PSN_BIT   = XLEN;
  localparam logic [ROB:0] DEPTH = (ROB+1)'(ROBW);

  logic [PKT-1:0] entries [ROBW];
  logic [ROB-1:0] head;
  logic [ROB-1:0] tail;
  logic [ROB:0]   count;
  logic [ROB:0]   free;

  logic [2:0]     write_en;
  logic [1:0]     num_write;
  logic [2:0]     retire_ok;
  logic [1:0]     num_retire;
  logic [2:0]     head_done;
  logic [2:0]     head_psn;
  logic [ROB-1:0] slot_idx [3];
  logic [PKT-1:0] head_pkt [3];

  assign free = DEPTH - count;

  // Stall looks only at the current occupancy; same-cycle retires free nothing yet.
  always_comb begin
    struct_stall = 3'b000;
    case (free)
      (ROB+1)'(0): struct_stall = 3'b111;
      (ROB+1)'(1): struct_stall = 3'b011;
      (ROB+1)'(2): struct_stall = 3'b001;
      default:     struct_stall = 3'b000;
    endcase
  end

  generate
    for (genvar k = 0; k < 3; k++) begin : g_way
      assign dispatch_index[k*ROB +: ROB] = tail + ROB'(2 - k);
      assign write_en[k] = rob_in[k*PKT + VALID_BIT] & ~struct_stall[k];
      assign retire_entry[k*PKT +: PKT] = entries[head + ROB'(2 - k)];
    end

    for (genvar j = 0; j < 3; j++) begin : g_head
      assign slot_idx[j]  = head + ROB'(j);
      assign head_pkt[j]  = entries[slot_idx[j]];
      assign head_done[j] = head_pkt[j][VALID_BIT] & head_pkt[j][COMP_BIT];
      assign head_psn[j]  = head_pkt[j][PSN_BIT];
    end

    for (genvar i = 0; i < ROBW; i++) begin : g_disp
      assign rob_entries_display[i*PKT +: PKT] = entries[i];
    end
  endgenerate

  // The retire run ends after the first entry that needs precise-state recovery.
  assign retire_ok = {head_done[0] & ~head_psn[0] & head_done[1] & ~head_psn[1] & head_done[2],
                      head_done[0] & ~head_psn[0] & head_done[1],
                      head_done[0]};

  always_comb begin
    num_retire = 2'd0;
    if (retire_ok[2])      num_retire = 2'd3;
    else if (retire_ok[1]) num_retire = 2'd2;
    else if (retire_ok[0]) num_retire = 2'd1;
  end

  always_comb begin
    num_write = 2'd0;
    if (write_en[0])      num_write = 2'd3;
    else if (write_en[1]) num_write = 2'd2;
    else if (write_en[2]) num_write = 2'd1;
  end

  // Later assignments win: completion, then retire clear, then squash or dispatch write.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROBW; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int w = 0; w < 3; w++) begin
        if (complete_valid[w] && entries[complete_entry[w*ROB +: ROB]][VALID_BIT]) begin
          entries[complete_entry[w*ROB +: ROB]][COMP_BIT]     <= 1'b1;
          entries[complete_entry[w*ROB +: ROB]][PSN_BIT]      <= precise_state_valid[w];
          entries[complete_entry[w*ROB +: ROB]][XLEN-1:0]     <= target_pc[w*XLEN +: XLEN];
        end
      end

      for (int j = 0; j < 3; j++) begin
        if (retire_ok[j]) begin
          entries[slot_idx[j]] <= '0;
        end
      end

      head <= head + ROB'(num_retire);

      if (BPRecoverEN) begin
        for (int i = 0; i < ROBW; i++) begin
          entries[i] <= '0;
        end
        tail  <= head + ROB'(num_retire);
        count <= '0;
      end else begin
        for (int w = 0; w < 3; w++) begin
          if (write_en[w]) begin
            entries[dispatch_index[w*ROB +: ROB]] <= {1'b1, rob_in[w*PKT +: PKT-1]};
          end
        end
        tail  <= tail + ROB'(num_write);
        count <= count + (ROB+1)'(num_write) - (ROB+1)'(num_retire);
      end
    end
  end

  assign head_display = head;
  assign tail_display = tail;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// tb_reorder_buffer: directed plus randomized stimulus checked against a program-order queue model.
module tb_reorder_buffer;
  localparam int ROB  = 5;
  localparam int PR   = 6;
  localparam int XLEN = 32;
  localparam int ROBW = 32;
  localparam int PKT  = 1 + 2*PR + 5 + 2 + XLEN;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [3*PKT-1:0]    rob_in;
  logic [2:0]          complete_valid;
  logic [3*ROB-1:0]    complete_entry;
  logic [2:0]          precise_state_valid;
  logic [3*XLEN-1:0]   target_pc;
  logic                BPRecoverEN;
  logic [3*ROB-1:0]    dispatch_index;
  logic [3*PKT-1:0]    retire_entry;
  logic [2:0]          struct_stall;
  logic [ROBW*PKT-1:0] rob_entries_display;
  logic [ROB-1:0]      head_display;
  logic [ROB-1:0]      tail_display;

  always #5 clock = ~clock;

  reorder_buffer #(.ROB(ROB), .PR(PR), .XLEN(XLEN)) dut (
    .clock               (clock),
    .reset               (reset),
    .rob_in              (rob_in),
    .complete_valid      (complete_valid),
    .complete_entry      (complete_entry),
    .precise_state_valid (precise_state_valid),
    .target_pc           (target_pc),
    .BPRecoverEN         (BPRecoverEN),
    .dispatch_index      (dispatch_index),
    .retire_entry        (retire_entry),
    .struct_stall        (struct_stall),
    .rob_entries_display (rob_entries_display),
    .head_display        (head_display),
    .tail_display        (tail_display)
  );

  typedef struct {
    logic [PR-1:0]   tnew;
    logic [PR-1:0]   told;
    logic [4:0]      arch;
    logic            completed;
    logic            psn;
    logic [XLEN-1:0] pc;
  } ent_t;

  // Model: live instructions in program order; q[i] lives at ROB index (mhead + i) mod ROBW.
  ent_t q[$];
  int   mhead;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT-1:0] pack(input ent_t e);
    return {1'b1, e.tnew, e.told, e.arch, e.completed, e.psn, e.pc};
  endfunction

  function automatic ent_t unpack(input logic [PKT-1:0] p);
    ent_t e;
    e.tnew      = p[PKT-2 -: PR];
    e.told      = p[PKT-2-PR -: PR];
    e.arch      = p[PKT-2-2*PR -: 5];
    e.completed = p[XLEN+1];
    e.psn       = p[XLEN];
    e.pc        = p[XLEN-1:0];
    return e;
  endfunction

  function automatic ent_t rand_ent(input bit allow_done);
    ent_t e;
    e.tnew      = PR'($urandom);
    e.told      = PR'($urandom);
    e.arch      = 5'($urandom);
    e.completed = allow_done && ($urandom_range(0, 7) == 0);
    e.psn       = e.completed && ($urandom_range(0, 3) == 0);
    e.pc        = $urandom;
    return e;
  endfunction

  task automatic idle_inputs();
    rob_in              = '0;
    complete_valid      = '0;
    complete_entry      = '0;
    precise_state_valid = '0;
    target_pc           = '0;
    BPRecoverEN         = 1'b0;
  endtask

  task automatic put_dispatch(input int w, input ent_t e);
    rob_in[w*PKT +: PKT] = pack(e);
  endtask

  task automatic put_complete(input int w, input int idx, input logic psv, input logic [XLEN-1:0] pc);
    complete_valid[w]                = 1'b1;
    complete_entry[w*ROB +: ROB]     = ROB'(idx);
    precise_state_valid[w]           = psv;
    target_pc[w*XLEN +: XLEN]        = pc;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int sz;
    int free;
    int nst;
    int n;
    int off;
    sz   = q.size();
    free = ROBW - sz;
    nst  = (free >= 3) ? 0 : 3 - free;
    n    = 0;
    for (int i = 0; i < 3 && i < sz; i++) begin
      if (!q[i].completed) break;
      n++;
      if (q[i].psn) break;
    end
    for (int w = 0; w < 3; w++) begin
      if (complete_valid[w]) begin
        off = (int'(complete_entry[w*ROB +: ROB]) - mhead + ROBW) % ROBW;
        if (off < sz) begin
          q[off].completed = 1'b1;
          q[off].psn       = precise_state_valid[w];
          q[off].pc        = target_pc[w*XLEN +: XLEN];
        end
      end
    end
    repeat (n) void'(q.pop_front());
    mhead = (mhead + n) % ROBW;
    if (BPRecoverEN) begin
      q.delete();
    end else begin
      for (int w = 2; w >= 0; w--) begin
        if (rob_in[w*PKT + PKT-1] && w >= nst) q.push_back(unpack(rob_in[w*PKT +: PKT]));
      end
    end
  endtask

  task automatic compare_all(input string ph);
    int sz;
    int nst;
    int mtail;
    int off;
    logic [2:0] exp_stall;
    logic [PKT-1:0] exp_pkt;
    sz        = q.size();
    nst       = (ROBW - sz >= 3) ? 0 : 3 - (ROBW - sz);
    mtail     = (mhead + sz) % ROBW;
    exp_stall = {nst >= 3, nst >= 2, nst >= 1};
    check({ph, "_head"}, 64'(head_display), 64'(mhead));
    check({ph, "_tail"}, 64'(tail_display), 64'(mtail));
    check({ph, "_stall"}, 64'(struct_stall), 64'(exp_stall));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_dispidx%0d", ph, k), 64'(dispatch_index[k*ROB +: ROB]),
            64'((mtail + 2 - k) % ROBW));
      exp_pkt = (2 - k < sz) ? pack(q[2 - k]) : '0;
      check($sformatf("%s_retire%0d", ph, k), 64'(retire_entry[k*PKT +: PKT]), 64'(exp_pkt));
    end
    for (int i = 0; i < ROBW; i++) begin
      off     = (i - mhead + ROBW) % ROBW;
      exp_pkt = (off < sz) ? pack(q[off]) : '0;
      check($sformatf("%s_entry%0d", ph, i), 64'(rob_entries_display[i*PKT +: PKT]), 64'(exp_pkt));
    end
  endtask

  task automatic step(input string ph);
    model_step();
    @(posedge clock);
    #1;
    compare_all(ph);
  endtask

  initial begin
    ent_t e;
    int   nd;
    int   idx;
    int   taken [3];
    bit   dup;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    mhead = 0;
    compare_all("reset");

    // Three dispatches, Told 1,2,3 on ways 2,1,0.
    for (int w = 2; w >= 0; w--) begin
      e = rand_ent(1'b0);
      e.told = PR'(3 - w);
      put_dispatch(w, e);
    end
    step("disp3");
    check("disp3_told_head", 64'(retire_entry[2*PKT + PKT-2-PR -: PR]), 64'(1));

    // Complete entries 2,1,0 (entry 1 is a taken branch to 32) while dispatching Told 4,5,6.
    idle_inputs();
    for (int w = 2; w >= 0; w--) begin
      e = rand_ent(1'b0);
      e.told = PR'(6 - w);
      put_dispatch(w, e);
      put_complete(w, w, (w == 1), (w == 1) ? 32'd32 : $urandom);
    end
    step("cmp3");
    idle_inputs();
    step("ret2");
    check("ret2_head_is_2", 64'(head_display), 64'(2));

    BPRecoverEN = 1'b1;
    for (int w = 2; w >= 0; w--) put_dispatch(w, rand_ent(1'b0));
    step("recover");

    // Fill to 30, then 31, then 32, then a dropped dispatch while full.
    for (int c = 0; c < 13; c++) begin
      idle_inputs();
      nd = (c == 10) ? 1 : 3;
      for (int j = 0; j < nd; j++) put_dispatch(2 - j, rand_ent(1'b0));
      step("fill");
    end
    check("full_stall", 64'(struct_stall), 64'(3'b111));

    for (int c = 0; c < 700; c++) begin
      idle_inputs();
      nd = $urandom_range(0, 3);
      for (int w = 2; w >= 0; w--) begin
        if (2 - w < nd) put_dispatch(w, rand_ent(1'b1));
        else rob_in[w*PKT +: PKT] = {1'b0, (PKT-1)'({$urandom, $urandom})};
      end
      for (int w = 2; w >= 0; w--) begin
        taken[w] = -1;
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 1) == 0) idx = (mhead + $urandom_range(0, 3)) % ROBW;
          else idx = (mhead + $urandom_range(0, q.size() + 1)) % ROBW;
          dup = 1'b0;
          for (int v = 2; v > w; v--) if (taken[v] == idx) dup = 1'b1;
          if (!dup) begin
            taken[w] = idx;
            put_complete(w, idx, ($urandom_range(0, 4) == 0), $urandom);
          end
        end
      end
      BPRecoverEN = ($urandom_range(0, 29) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
